// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared types and constants for the rv32im fetch front end
// Contents: fetch FSM state encoding, Wishbone word select, sequential PC step.
package rv32im_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_FETCH_BUS = 2'd2,
        ST_VEC_BUS   = 2'd3
    } fetch_state_e;

    localparam logic [3:0] WB_SEL_WORD = 4'b1111;
    localparam int         PC_STEP     = 4;

endpackage

// File: rtl/rv32im_fetch_queue_if.sv
// rtl/rv32im_fetch_queue_if.sv - Wishbone-classic master bus plus core arbiter request/grant
// master: ctrl_req_o, adr_o (word address), cyc_o, stb_o, sel_o out; ctrl_grant_i, master_dat_i, ack_i, err_i in.
// slave:  the mirror of master.
interface rv32im_fetch_queue_if #(
    parameter int XLEN = 32
) ();
    logic            ctrl_req_o;
    logic            ctrl_grant_i;
    logic [XLEN-1:0] master_dat_i;
    logic            ack_i;
    logic            err_i;
    logic [XLEN-3:0] adr_o;
    logic            cyc_o;
    logic            stb_o;
    logic [3:0]      sel_o;

    modport master (
        output ctrl_req_o, adr_o, cyc_o, stb_o, sel_o,
        input  ctrl_grant_i, master_dat_i, ack_i, err_i
    );

    modport slave (
        input  ctrl_req_o, adr_o, cyc_o, stb_o, sel_o,
        output ctrl_grant_i, master_dat_i, ack_i, err_i
    );
endinterface

// File: rtl/rv32im_fetch_fifo.sv
// rtl/rv32im_fetch_fifo.sv - synchronous FIFO of {instruction, pc} fetch entries
// Ports: clk_i, reset_i (sync active-high); push_i with push_instr_i/push_pc_i; pop_i; flush_i
// (empties, wins over push/pop); count_o occupancy; head_instr_o/head_pc_o (0 while empty).
module rv32im_fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [XLEN-1:0]            push_instr_i,
    input  logic [XLEN-1:0]            push_pc_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [XLEN-1:0]            head_instr_o,
    output logic [XLEN-1:0]            head_pc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked while empty so nothing undefined leaks out.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            instr_mem_q[wr_ptr_q] <= push_instr_i;
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = (count_q != '0) ? instr_mem_q[rd_ptr_q] : '0;
    assign head_pc_o    = (count_q != '0) ? pc_mem_q[rd_ptr_q]    : '0;

endmodule

// File: rtl/rv32im_fetch_queue.sv
// rtl/rv32im_fetch_queue.sv - rv32im instruction prefetch queue with redirect and interrupt vectoring
// Ports: clk_i, reset_i (sync active-high); pc_write_i/pc_i redirect; advance_i consumes head;
// data_ready_o/instruction_o/pc_o head entry; fetch_err_o bus error pulse; interrupt_trigger_i,
// vtable_addr_i, vtable_offset_i vector lookup; interrupt_pc_o/interrupt_pc_write_o handler redirect;
// bus: Wishbone-classic master with arbiter request/grant.
module rv32im_fetch_queue
    import rv32im_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 pc_write_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic                 advance_i,
    output logic                 data_ready_o,
    output logic [XLEN-1:0]      instruction_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 fetch_err_o,
    input  logic                 interrupt_trigger_i,
    input  logic [XLEN-1:0]      vtable_addr_i,
    input  logic [XLEN-1:0]      vtable_offset_i,
    output logic [XLEN-1:0]      interrupt_pc_o,
    output logic                 interrupt_pc_write_o,
    rv32im_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            irq_pending_q, irq_pending_d;
    logic            halted_q, halted_d;
    logic            stale_q, stale_d;
    logic            fetch_err_q, fetch_err_d;
    logic [XLEN-1:0] int_pc_q, int_pc_d;
    logic            int_pc_write_q, int_pc_write_d;

    logic [CW-1:0]   count, count_next;
    logic            push, pop, flush, redirect, vec_ack, in_bus;
    logic [XLEN-1:0] vec_addr;
    logic            unused_low_bits;

    assign in_bus   = (state_q == ST_FETCH_BUS) || (state_q == ST_VEC_BUS);
    assign vec_addr = vtable_addr_i + vtable_offset_i;
    // The core echoes our own interrupt redirect back; that cycle its pc_write_i is ignored.
    assign redirect = pc_write_i && !int_pc_write_q;
    assign vec_ack  = (state_q == ST_VEC_BUS) && bus.ack_i && !bus.err_i;
    assign flush    = redirect || vec_ack;
    // A beat already in flight at a redirect completes but its data belongs to the old path.
    assign push     = (state_q == ST_FETCH_BUS) && bus.ack_i && !bus.err_i && !stale_q && !redirect;
    assign pop      = advance_i && (count != '0) && !flush;
    assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);

    rv32im_fetch_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (push),
        .push_instr_i (bus.master_dat_i),
        .push_pc_i    (fetch_pc_q),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (count),
        .head_instr_o (instruction_o),
        .head_pc_o    (pc_o)
    );

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        irq_pending_d  = irq_pending_q || interrupt_trigger_i;
        halted_d       = halted_q;
        stale_d        = stale_q;
        fetch_err_d    = 1'b0;
        int_pc_d       = int_pc_q;
        int_pc_write_d = 1'b0;

        if (redirect) begin
            fetch_pc_d = pc_i;
            halted_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (irq_pending_q || ((count < CW'(DEPTH)) && !halted_q)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.ctrl_grant_i) state_d = irq_pending_q ? ST_VEC_BUS : ST_FETCH_BUS;
            end
            ST_FETCH_BUS: begin
                if (bus.err_i) begin
                    fetch_err_d = 1'b1;
                    halted_d    = 1'b1;
                    stale_d     = 1'b0;
                    state_d     = ST_IDLE;
                end else if (bus.ack_i) begin
                    stale_d = 1'b0;
                    if (push) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    // Keep the bus for a back-to-back beat only while there is room and nothing else to do.
                    if (irq_pending_q || halted_q || (count_next >= CW'(DEPTH))) state_d = ST_IDLE;
                end else if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            ST_VEC_BUS: begin
                if (bus.err_i) begin
                    fetch_err_d   = 1'b1;
                    halted_d      = 1'b1;
                    irq_pending_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (bus.ack_i) begin
                    int_pc_d       = bus.master_dat_i;
                    int_pc_write_d = 1'b1;
                    fetch_pc_d     = bus.master_dat_i;
                    irq_pending_d  = 1'b0;
                    halted_d       = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            fetch_pc_q     <= RESET_PC;
            irq_pending_q  <= 1'b0;
            halted_q       <= 1'b0;
            stale_q        <= 1'b0;
            fetch_err_q    <= 1'b0;
            int_pc_q       <= '0;
            int_pc_write_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            irq_pending_q  <= irq_pending_d;
            halted_q       <= halted_d;
            stale_q        <= stale_d;
            fetch_err_q    <= fetch_err_d;
            int_pc_q       <= int_pc_d;
            int_pc_write_q <= int_pc_write_d;
        end
    end

    assign bus.ctrl_req_o = (state_q != ST_IDLE);
    assign bus.cyc_o      = in_bus;
    assign bus.stb_o      = in_bus;
    assign bus.sel_o      = in_bus ? WB_SEL_WORD : 4'b0000;
    assign bus.adr_o      = (state_q == ST_FETCH_BUS) ? fetch_pc_q[XLEN-1:2] :
                            (state_q == ST_VEC_BUS)   ? vec_addr[XLEN-1:2]   : '0;

    assign data_ready_o         = (count != '0);
    assign fetch_err_o          = fetch_err_q;
    assign interrupt_pc_o       = int_pc_q;
    assign interrupt_pc_write_o = int_pc_write_q;

    assign unused_low_bits = ^{fetch_pc_q[1:0], vec_addr[1:0]};

endmodule

// File: tb/tb_rv32im_fetch_queue.sv
// tb/tb_rv32im_fetch_queue.sv - scoreboard bench for rv32im_fetch_queue with a Wishbone slave model
module tb_rv32im_fetch_queue;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic        pc_write_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        advance_i = 1'b0;
    logic        interrupt_trigger_i = 1'b0;
    logic [31:0] vtable_addr_i = '0;
    logic [31:0] vtable_offset_i = '0;
    logic        data_ready_o, fetch_err_o, interrupt_pc_write_o;
    logic [31:0] instruction_o, pc_o, interrupt_pc_o;

    rv32im_fetch_queue_if #(.XLEN(XLEN)) bus ();

    rv32im_fetch_queue #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .reset_i(reset_i), .pc_write_i(pc_write_i), .pc_i(pc_i),
        .advance_i(advance_i), .data_ready_o(data_ready_o), .instruction_o(instruction_o),
        .pc_o(pc_o), .fetch_err_o(fetch_err_o), .interrupt_trigger_i(interrupt_trigger_i),
        .vtable_addr_i(vtable_addr_i), .vtable_offset_i(vtable_offset_i),
        .interrupt_pc_o(interrupt_pc_o), .interrupt_pc_write_o(interrupt_pc_write_o),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] sb_ins[$];

    logic        gnt_en = 1'b1, ack_en = 1'b1, hold_en = 1'b0, err_en = 1'b0;
    logic [29:0] hold_word = '0, err_word = '0;
    int          beats = 0, vec_reads = 0;
    logic [29:0] last_adr = '0;

    function automatic logic [31:0] mem_word(input logic [29:0] wadr);
        logic [31:0] b;
        b = {wadr, 2'b00};
        if (b == 32'h0030_0008) return 32'h0000_2000;
        return {16'hC0DE, b[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
        sb_pc.push_back(pc);
        sb_ins.push_back(ins);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_pc.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(sb_pc.size()), 32'd0);
        sb_pc.delete();
        sb_ins.delete();
    endtask

    // Wishbone slave: responds in the same cycle as the strobe unless held or erroring.
    initial begin
        bus.ctrl_grant_i = 1'b0;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.master_dat_i = '0;
        forever begin
            tick();
            bus.ctrl_grant_i = gnt_en & bus.ctrl_req_o;
            if (bus.stb_o) begin
                bus.master_dat_i = mem_word(bus.adr_o);
                bus.err_i = err_en && (bus.adr_o == err_word);
                bus.ack_i = ack_en && !bus.err_i && !(hold_en && bus.adr_o == hold_word);
            end else begin
                bus.master_dat_i = '0;
                bus.ack_i = 1'b0;
                bus.err_i = 1'b0;
            end
        end
    end

    // Monitor: every consumed head entry is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.stb_o && bus.ack_i) begin
                beats++;
                last_adr = bus.adr_o;
            end
            if (bus.stb_o && bus.adr_o == 30'h000C_0002) vec_reads++;
            if (!reset_i && !pc_write_i && advance_i && data_ready_o) begin
                if (sb_pc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h expected no entry", pc_o);
                end else begin
                    check("head_pc", pc_o, sb_pc.pop_front());
                    check("head_instr", instruction_o, sb_ins.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int stbs;
        logic found;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_data_ready", 32'(data_ready_o), 32'd0);
        check("rst_instr", instruction_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_cyc_stb", 32'({bus.cyc_o, bus.stb_o}), 32'd0);
        check("rst_req", 32'(bus.ctrl_req_o), 32'd0);
        check("rst_irq_write", 32'(interrupt_pc_write_o), 32'd0);
        check("rst_fetch_err", 32'(fetch_err_o), 32'd0);
        check("rst_sel", 32'(bus.sel_o), 32'd0);

        // Streaming fetch with ack every cycle
        tick();
        reset_i = 1'b0;
        advance_i = 1'b1;
        expect_entry(32'h0, 32'hC0DE0000);
        expect_entry(32'h4, 32'hC0DE0004);
        expect_entry(32'h8, 32'hC0DE0008);
        expect_entry(32'hC, 32'hC0DE000C);
        expect_entry(32'h10, 32'hC0DE0010);
        expect_entry(32'h14, 32'hC0DE0014);
        wait_drain("stream_drain", 100);
        advance_i = 1'b0;

        // Fill to DEPTH without consumption, then one pop lets exactly one more beat out
        reset_i = 1'b1;
        tick();
        base = beats;
        reset_i = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        check("fill_beats", 32'(beats - base), 32'd4);
        check("fill_req_dropped", 32'(bus.ctrl_req_o), 32'd0);
        check("fill_ready", 32'(data_ready_o), 32'd1);
        check("fill_head_pc", pc_o, 32'h0);
        expect_entry(32'h0, 32'hC0DE0000);
        tick();
        advance_i = 1'b1;
        tick();
        advance_i = 1'b0;
        repeat (10) tick();
        check("refill_beats", 32'(beats - base), 32'd5);
        check("refill_adr", 32'(last_adr), 32'h4);
        expect_entry(32'h4, 32'hC0DE0004);
        expect_entry(32'h8, 32'hC0DE0008);
        expect_entry(32'hC, 32'hC0DE000C);
        expect_entry(32'h10, 32'hC0DE0010);
        advance_i = 1'b1;
        wait_drain("refill_drain", 50);
        advance_i = 1'b0;

        // Redirect while the beat at 0x8 is stalled on the bus
        reset_i = 1'b1;
        hold_en = 1'b1;
        hold_word = 30'h2;
        tick();
        reset_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            found = bus.stb_o && (bus.adr_o == 30'h2);
        end
        check("stall_at_8", 32'(found), 32'd1);
        pc_i = 32'h100;
        pc_write_i = 1'b1;
        tick();
        pc_write_i = 1'b0;
        hold_en = 1'b0;
        @(negedge clk);
        check("redirect_flush", 32'(data_ready_o), 32'd0);
        expect_entry(32'h100, 32'hC0DE0100);
        expect_entry(32'h104, 32'hC0DE0104);
        expect_entry(32'h108, 32'hC0DE0108);
        tick();
        advance_i = 1'b1;
        wait_drain("redirect_drain", 50);
        advance_i = 1'b0;

        // Interrupt: vector read at 0x00300008, handler 0x2000
        vtable_addr_i = 32'h0030_0000;
        vtable_offset_i = 32'h8;
        base = vec_reads;
        interrupt_trigger_i = 1'b1;
        tick();
        interrupt_trigger_i = 1'b0;
        for (int n = 0; n < 30 && !interrupt_pc_write_o; n++) @(negedge clk);
        check("irq_write", 32'(interrupt_pc_write_o), 32'd1);
        check("irq_pc", interrupt_pc_o, 32'h2000);
        check("irq_vec_read", 32'(vec_reads > base), 32'd1);
        @(negedge clk);
        check("irq_write_pulse", 32'(interrupt_pc_write_o), 32'd0);
        expect_entry(32'h2000, 32'hC0DE2000);
        expect_entry(32'h2004, 32'hC0DE2004);
        tick();
        advance_i = 1'b1;
        wait_drain("irq_drain", 50);
        advance_i = 1'b0;

        // Bus error on fetch of 0x40 halts fetching until a redirect
        pc_i = 32'h30;
        pc_write_i = 1'b1;
        err_en = 1'b1;
        err_word = 30'h10;
        tick();
        pc_write_i = 1'b0;
        advance_i = 1'b1;
        expect_entry(32'h30, 32'hC0DE0030);
        expect_entry(32'h34, 32'hC0DE0034);
        expect_entry(32'h38, 32'hC0DE0038);
        expect_entry(32'h3C, 32'hC0DE003C);
        for (int n = 0; n < 60 && !fetch_err_o; n++) @(negedge clk);
        check("err_pulse", 32'(fetch_err_o), 32'd1);
        @(negedge clk);
        check("err_pulse_end", 32'(fetch_err_o), 32'd0);
        stbs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.stb_o) stbs++;
        end
        check("halted_no_stb", 32'(stbs), 32'd0);
        wait_drain("err_drain", 20);
        tick();
        err_en = 1'b0;
        pc_i = 32'h80;
        pc_write_i = 1'b1;
        tick();
        pc_write_i = 1'b0;
        expect_entry(32'h80, 32'hC0DE0080);
        expect_entry(32'h84, 32'hC0DE0084);
        wait_drain("resume_drain", 50);
        advance_i = 1'b0;

        // Reset during FETCH_BUS
        ack_en = 1'b0;
        pc_i = 32'h200;
        pc_write_i = 1'b1;
        tick();
        pc_write_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            found = bus.stb_o;
        end
        check("busy_before_reset", 32'(found), 32'd1);
        reset_i = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_cyc_stb", 32'({bus.cyc_o, bus.stb_o}), 32'd0);
        check("mid_rst_req", 32'(bus.ctrl_req_o), 32'd0);
        check("mid_rst_ready", 32'(data_ready_o), 32'd0);
        tick();
        reset_i = 1'b0;
        ack_en = 1'b1;
        advance_i = 1'b1;
        expect_entry(32'h0, 32'hC0DE0000);
        expect_entry(32'h4, 32'hC0DE0004);
        wait_drain("post_rst_drain", 50);
        advance_i = 1'b0;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32im_fetch_queue.md
Name: rv32im_fetch_queue

Overview:
Instruction fetch front end feeding the rv32im decode stage. Acts as a Wishbone-classic bus master and fetches sequential instruction words ahead into a small FIFO. Presents the head instruction and its PC with a ready/advance handshake. Handles PC redirects (jumps/branches/mret) by flushing, and services interrupts by reading the vector table and issuing its own redirect.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h00000000, fetch PC after reset

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
pc_write_i  in  1  redirect request from core
pc_i  in  XLEN  redirect target (byte address, word aligned)
advance_i  in  1  core consumes head entry
data_ready_o  out  1  head entry valid
instruction_o  out  XLEN  head instruction
pc_o  out  XLEN  byte address of head instruction
fetch_err_o  out  1  one-cycle pulse on bus error
interrupt_trigger_i  in  1  interrupt request pulse
vtable_addr_i  in  XLEN  vector table base (byte)
vtable_offset_i  in  XLEN  vector offset (byte)
interrupt_pc_o  out  XLEN  handler address read from table
interrupt_pc_write_o  out  1  one-cycle redirect pulse to core
ctrl_req_o  out  1  bus request to core arbiter
ctrl_grant_i  in  1  bus granted
master_dat_i  in  XLEN  read data
ack_i  in  1  bus ack
err_i  in  1  bus error
adr_o  out  XLEN-2  word address (byte address [XLEN-1:2])
cyc_o  out  1  bus cycle
stb_o  out  1  strobe
sel_o  out  4  byte select, always 4'b1111 while stb_o

Behaviour:
- Reset: FIFO empty, fetch_pc=RESET_PC, FSM IDLE, all outputs 0 (instruction_o/pc_o 0), irq_pending=0, halted=0, stale=0.
- FIFO: entry = {instruction, pc}. Push on good ack in FETCH_BUS; pop when advance_i & data_ready_o. Simultaneous push+pop keeps count. advance_i while empty is ignored. data_ready_o = count!=0, combinational from state.
- FSM states: IDLE, REQ, FETCH_BUS, VEC_BUS.
  - IDLE: go to REQ if irq_pending, or if (count<DEPTH & ~halted). ctrl_req_o=0.
  - REQ: ctrl_req_o=1; on ctrl_grant_i go to VEC_BUS if irq_pending, else FETCH_BUS.
  - FETCH_BUS: cyc_o=stb_o=1, adr_o=fetch_pc[XLEN-1:2]. On ack_i: if ~stale, push and fetch_pc+=4. Then back-to-back: stay if irq_pending=0, count after this cycle<DEPTH, ~halted; else IDLE (drop ctrl_req_o).
  - VEC_BUS: adr_o=(vtable_addr_i+vtable_offset_i)[XLEN-1:2]. On ack_i: interrupt_pc_o<=master_dat_i, interrupt_pc_write_o=1 next cycle for exactly one cycle, flush FIFO, fetch_pc<=master_dat_i, irq_pending=0, go IDLE.
- Single beat per strobe; one outstanding beat max. Latency: grant to first push = ack latency; empty FIFO after redirect yields data_ready_o no earlier than 3 cycles later (IDLE->REQ->BUS->ack).
- Redirect (pc_write_i): same cycle FIFO flushed, fetch_pc<=pc_i, halted=0; advance_i that cycle ignored. If a beat is in flight, stale=1 and bus cycle completes; its data is discarded; stale clears on that ack/err.
- Redirect coinciding with interrupt_pc_write_o: interrupt wins, pc_write_i ignored.
- interrupt_trigger_i sets irq_pending; taken after the current beat completes. Retrigger while pending has no effect.
- err_i (any bus state): no push, fetch_err_o pulses, halted=1 (fetching stops until next redirect). err in VEC_BUS: no redirect, irq_pending=0.
- ack_i/err_i outside a bus state ignored. Loss of grant mid-beat is not legal; not handled.
- reset_i mid-transaction: cyc_o/stb_o drop next cycle, all state to reset values.

Decomposition:
- Shared package rv32im_pkg: FSM state encodings, WB_SEL_WORD=4'b1111, PC_STEP=4.
- One sub-module: rv32im_fetch_fifo (synchronous FIFO, DEPTH, push/pop/flush, count, head outputs).

Test Plan:
- Reset, ack every cycle, advance_i=1 -> data_ready_o pulses with pc_o 0x0,0x4,0x8… and instruction_o equal to memory words in order.
- advance_i=0, DEPTH=4 -> exactly 4 beats issued, ctrl_req_o drops, count=4; one pop -> one more fetch of pc 0x10.
- pc_write_i=1, pc_i=0x100 while beat at 0x8 in flight -> 0x8 data discarded, next pc_o=0x100.
- interrupt_trigger_i, vtable 0x00300000 + offset 0x8, table word 0x2000 -> bus read adr_o=0x000C0002, interrupt_pc_write_o one-cycle with interrupt_pc_o=0x2000, next pc_o=0x2000.
- err_i on fetch of 0x40 -> fetch_err_o one pulse, no push, no further stb_o until pc_write_i with pc_i=0x80.
- reset_i asserted during FETCH_BUS -> next cycle cyc_o=stb_o=ctrl_req_o=0, data_ready_o=0, fetch resumes at RESET_PC.
